// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the instruction memory and fills the IF/ID register.
// Optional misaligned-redirect trap is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    logic [31:0] pc_p0;
    logic [31:0] pc_plus4_p0;
    logic [31:0] jump_target_p0;
    logic [31:0] redirect_target_p0;
    logic        redirect_p0;

    always_comb begin
        pc_plus4_p0        = pc_p0 + 32'd4;
        jump_target_p0     = {pc_plus4_p0[31:28], jump_index, 2'b00};
        redirect_p0        = branch_taken | jump;
        redirect_target_p0 = branch_taken ? branch_target : jump_target_p0;
    end

    assign imem_addr = pc_p0;

    // IF -> IF/ID boundary
`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned_p0;
    assign misaligned_p0 = redirect_p0 && (redirect_target_p0[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0       <= RESET_PC;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (fetch_fault) begin
            // Trapped: PC frozen, decode sees only bubbles until reset.
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (redirect_p0) begin
            if (misaligned_p0) begin
                fetch_fault <= 1'b1;
            end else begin
                pc_p0 <= redirect_target_p0;
            end
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            pc_p0       <= pc_plus4_p0;
            if_id_instr <= imem_instr;
            if_id_pc4   <= pc_plus4_p0;
            if_id_valid <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0       <= RESET_PC;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (redirect_p0) begin
            // Low address bits are dropped so the PC always stays word-aligned.
            pc_p0       <= redirect_target_p0 & ~32'h3;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            pc_p0       <= pc_plus4_p0;
            if_id_instr <= imem_instr;
            if_id_pc4   <= pc_plus4_p0;
            if_id_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table followed by randomized traffic against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, jump;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] imem_addr, imem_instr, if_id_instr, if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    logic [31:0] mem [0:1023];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[11:2]];

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_index(jump_index),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
`ifdef FETCH_ALIGN_CHECK_EN
        , .fetch_fault(fetch_fault)
`endif
    );

    typedef struct {
        logic        r, s, b;
        logic [31:0] bt;
        logic        j;
        logic [25:0] ji;
        logic [31:0] ea, ei, ep;
        logic        ev, ef;
    } vec_t;

    vec_t tbl [$];

    // behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_fault;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, s, b, input logic [31:0] bt, input logic j,
                                input logic [25:0] ji, input logic [31:0] ea, ei, ep,
                                input logic ev, ef);
        vec_t v;
        v.r = r; v.s = s; v.b = b; v.bt = bt; v.j = j; v.ji = ji;
        v.ea = ea; v.ei = ei; v.ep = ep; v.ev = ev; v.ef = ef;
        return v;
    endfunction

    task automatic drive(input logic r, s, b, input logic [31:0] bt, input logic j, input logic [25:0] ji);
        reset = r; stall = s; branch_taken = b; branch_target = bt; jump = j; jump_index = ji;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [31:0] p4, tgt;
        p4 = m_pc + 32'd4;
        if (reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
        end else if (m_fault) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (branch_taken || jump) begin
            tgt = branch_taken ? branch_target : {p4[31:28], jump_index, 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
            if (tgt % 4 != 0) m_fault = 1'b1;
            else m_pc = tgt;
`else
            m_pc = tgt - (tgt % 4);
`endif
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!stall) begin
            m_instr = mem[(m_pc / 4) % 1024];
            m_pc4   = p4;
            m_pc    = p4;
            m_valid = 1'b1;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h2001000A; mem[1] = 32'h2002000B;
        mem[2] = 32'h00221820; mem[3] = 32'hAC030000;

        //            r  s  b  bt            j  ji    addr          instr         pc4           v  f
        tbl.push_back(mk(1, 0, 0, 32'h0,         0, 26'h0, 32'h0,        32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'h4,        32'h2001000A, 32'h4,        1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'h8,        32'h2002000B, 32'h8,        1, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,         0, 26'h0, 32'h8,        32'h2002000B, 32'h8,        1, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,         0, 26'h0, 32'h8,        32'h2002000B, 32'h8,        1, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,         0, 26'h0, 32'h8,        32'h2002000B, 32'h8,        1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'hC,        32'h00221820, 32'hC,        1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'h10,       32'hAC030000, 32'h10,       1, 0));
        tbl.push_back(mk(0, 1, 1, 32'h40,        1, 26'h5, 32'h40,       32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'h44,       32'hA0000010, 32'h44,       1, 0));
        tbl.push_back(mk(0, 0, 1, 32'h1000_0010, 0, 26'h0, 32'h1000_0010, 32'h0,       32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         1, 26'h3, 32'h1000_000C, 32'h0,       32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'h1000_0010, 32'hAC030000, 32'h1000_0010, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         0, 26'h0, 32'h0,        32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'h4,        32'h2001000A, 32'h4,        1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'h8,        32'h2002000B, 32'h8,        1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'hC,        32'h00221820, 32'hC,        1, 0));
        tbl.push_back(mk(0, 1, 0, 32'h0,         0, 26'h0, 32'hC,        32'h00221820, 32'hC,        1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,         0, 26'h0, 32'h0,        32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 26'h0, 32'hFFFF_FFFC, 32'h0,       32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'h0,        32'hA00003FF, 32'h0,        1, 0));
`ifdef FETCH_ALIGN_CHECK_EN
        tbl.push_back(mk(0, 0, 1, 32'h42,        0, 26'h0, 32'h0,        32'h0,        32'h0,        0, 1));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'h0,        32'h0,        32'h0,        0, 1));
        tbl.push_back(mk(0, 0, 1, 32'h80,        0, 26'h0, 32'h0,        32'h0,        32'h0,        0, 1));
`else
        tbl.push_back(mk(0, 0, 1, 32'h42,        0, 26'h0, 32'h40,       32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'h44,       32'hA0000010, 32'h44,       1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0,         0, 26'h0, 32'h48,       32'hA0000011, 32'h48,       1, 0));
`endif
        tbl.push_back(mk(1, 0, 0, 32'h0,         0, 26'h0, 32'h0,        32'h0,        32'h0,        0, 0));

        drive(1, 0, 0, 32'h0, 0, 26'h0);
        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].bt, tbl[i].j, tbl[i].ji);
            @(posedge clk); #1;
            chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].ea);
            chk($sformatf("vec%0d if_id_instr", i), if_id_instr, tbl[i].ei);
            chk($sformatf("vec%0d if_id_pc4", i), if_id_pc4, tbl[i].ep);
            chk($sformatf("vec%0d if_id_valid", i), {31'h0, if_id_valid}, {31'h0, tbl[i].ev});
`ifdef FETCH_ALIGN_CHECK_EN
            chk($sformatf("vec%0d fetch_fault", i), {31'h0, fetch_fault}, {31'h0, tbl[i].ef});
`endif
        end

        // Randomized traffic; the table ended in reset, so the model starts from reset state.
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] bt;
            bt = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom_range(0, 1023) * 4);
            if ($urandom_range(0, 40) == 0) bt[1:0] = 2'($urandom_range(1, 3));
            drive($urandom_range(0, 60) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0, bt, $urandom_range(0, 11) == 0, 26'($urandom));
            model_step();
            @(posedge clk); #1;
            chk($sformatf("rnd%0d imem_addr", i), imem_addr, m_pc);
            chk($sformatf("rnd%0d if_id_instr", i), if_id_instr, m_instr);
            chk($sformatf("rnd%0d if_id_pc4", i), if_id_pc4, m_pc4);
            chk($sformatf("rnd%0d if_id_valid", i), {31'h0, if_id_valid}, {31'h0, m_valid});
`ifdef FETCH_ALIGN_CHECK_EN
            chk($sformatf("rnd%0d fetch_fault", i), {31'h0, fetch_fault}, {31'h0, m_fault});
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the MIPS core: owns the program counter, drives the word address into the instruction memory, and registers the returned instruction into the IF/ID pipeline register. It is directly upstream of the instruction memory and directly upstream of decode. It handles sequential fetch, branch and jump redirects, and decode-requested stalls. The instruction memory is combinational read: `instruction = mem[address[11:2]]`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `stall`  input  1: from hazard unit; hold the PC and IF/ID contents.
- `branch_taken`  input  1: redirect to `branch_target` (resolved in a later stage).
- `branch_target`  input  32: absolute byte address of the branch destination.
- `jump`  input  1: redirect to the J-type target.
- `jump_index`  input  26: instr[25:0] of the jump.
- `imem_addr`  output  32: byte address to the instruction memory; equals the PC.
- `imem_instr`  input  32: instruction word returned combinationally by the memory.
- `if_id_instr`  output  32: registered instruction.
- `if_id_pc4`  output  32: registered PC+4 of that instruction.
- `if_id_valid`  output  1: IF/ID holds a real instruction (0 = bubble).
- `fetch_fault`  output  1: misaligned redirect flag (present only with `FETCH_ALIGN_CHECK_EN`).

## Operation
- State: `pc` (32b), IF/ID register (`if_id_instr`, `if_id_pc4`, `if_id_valid`).
- `imem_addr = pc` (combinational, no extra latency).
- Jump target: {pc_plus4[31:28], jump_index, 2'b00}, where pc_plus4 = pc + 4.
- Per-edge priority, highest first:
  - `reset`: pc ← RESET_PC; if_id_instr ← 0; if_id_pc4 ← 0; if_id_valid ← 0; fetch_fault ← 0.
  - `branch_taken`: pc ← branch_target. IF/ID ← bubble (instr 0, pc4 0, valid 0). Wins over `jump` and `stall`.
  - `jump`: pc ← jump target. IF/ID ← bubble. Wins over `stall`.
  - `stall`: pc and IF/ID unchanged.
  - Normal: pc ← pc + 4; if_id_instr ← imem_instr; if_id_pc4 ← pc + 4; if_id_valid ← 1.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0. No memory-size wrap is applied here; the memory ignores upper bits.
- Bubble instr 32'h0000_0000 decodes as nop (`sll $0,$0,0`).
- No delay slot: the instruction fetched in the redirect cycle is discarded.

## Timing
- Reset values: pc = RESET_PC, imem_addr = RESET_PC, if_id_instr = 0, if_id_pc4 = 0, if_id_valid = 0, fetch_fault = 0.
- First edge after reset deasserts: IF/ID captures mem[RESET_PC>>2] and valid rises. Latency from PC to IF/ID is 1 cycle.
- Redirect asserted in cycle N:
  - `imem_addr` = target in cycle N+1.
  - IF/ID is a bubble in N+1.
  - The target instruction is valid in IF/ID in cycle N+2.
- Stall held for k cycles freezes all outputs for k cycles. Fetch resumes on the first unstalled edge with no lost or duplicated instruction.
- Reset mid-stall or mid-redirect: reset wins; outputs take reset values on that edge.
- Redirect inputs are sampled only at the edge; there is no handshake and no acknowledgment.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect whose target[1:0] ≠ 0 leaves pc unchanged, loads a bubble, and sets `fetch_fault` ← 1 (sticky until reset).
  - While `fetch_fault` = 1, the stage behaves as a permanent stall with bubble output.
- Not defined:
  - Target bits [1:0] are forced to 0 on load.
  - The `fetch_fault` port is absent.

## Test plan
- Reset, then free-run 4 cycles with memory {0x2001000A, 0x2002000B, 0x00221820, 0xAC030000} → IF/ID shows those words with pc4 4, 8, 12, 16, valid = 1; imem_addr 0x0 → 0x4 → 0x8 → 0xC → 0x10.
- Stall high for 3 cycles while pc = 0x8 → imem_addr stays 0x8, IF/ID holds 0x2002000B / pc4 8. Next edge loads 0x00221820 / pc4 12.
- branch_taken = 1, branch_target = 0x40, with stall = 1 and jump = 1 in the same cycle → next cycle pc = 0x40, valid = 0; the following cycle IF/ID pc4 = 0x44, valid = 1.
- jump = 1, jump_index = 26'h0000003 at pc = 0x1000_0010 → pc = 0x1000_000C, bubble, then fetch continues from 0x1000_000C.
- reset asserted during an active stall at pc = 0xC → pc = 0, all IF/ID outputs 0, valid = 0. With pc forced near 0xFFFF_FFFC, one free-run edge → pc = 0x0.
- With `FETCH_ALIGN_CHECK_EN`, branch_target = 0x42 → fetch_fault = 1, pc unchanged, valid = 0 until reset. Without the macro, the same stimulus → pc = 0x40.
